// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with true-LRU replacement and saturating
// direction counters; combinational lookup with same-cycle update bypass.
module btb_assoc #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned CTR_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    input  logic              update,
    input  logic [ADDR_W-1:0] updatePC,
    input  logic [ADDR_W-1:0] updateTarget,
    input  logic              updateTaken,
    input  logic              flush,
    output logic              valid,
    output logic [ADDR_W-1:0] target,
    output logic              predictedTaken,
    output logic              evict
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(NUM_WAYS - 1);

    logic              r_valid  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]  r_tag    [NUM_SETS][NUM_WAYS];
    logic [ADDR_W-1:0] r_target [NUM_SETS][NUM_WAYS];
    logic [CTR_W-1:0]  r_ctr    [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  r_age    [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;

    logic              w_lk_hit;
    logic [ADDR_W-1:0] w_lk_target;
    logic [CTR_W-1:0]  w_lk_ctr;

    logic              w_up_hit;
    logic [WAY_W-1:0]  w_up_hit_way;
    logic              w_free_found;
    logic [WAY_W-1:0]  w_free_way;
    logic [WAY_W-1:0]  w_lru_way;
    logic [WAY_W-1:0]  w_way;
    logic [CTR_W-1:0]  w_old_ctr;
    logic [ADDR_W-1:0] w_old_target;
    logic [WAY_W-1:0]  w_touched_age;
    logic [CTR_W-1:0]  w_new_ctr;
    logic [ADDR_W-1:0] w_new_target;
    logic [WAY_W-1:0]  w_new_age [NUM_WAYS];
    logic              w_bypass;
    logic              w_unused;

    assign w_lk_idx = PC[IDX_W+1:2];
    assign w_lk_tag = PC[ADDR_W-1:IDX_W+2];
    assign w_up_idx = updatePC[IDX_W+1:2];
    assign w_up_tag = updatePC[ADDR_W-1:IDX_W+2];
    assign w_unused = ^{PC[1:0], updatePC[1:0]};

    // Fetch-side tag match across the indexed set
    always_comb begin
        w_lk_hit    = 1'b0;
        w_lk_target = '0;
        w_lk_ctr    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_hit    = 1'b1;
                w_lk_target = r_target[w_lk_idx][w];
                w_lk_ctr    = r_ctr[w_lk_idx][w];
            end
        end
    end

    // Update-side way selection: hit way, else lowest free way, else LRU way
    always_comb begin
        w_up_hit     = 1'b0;
        w_up_hit_way = '0;
        w_free_found = 1'b0;
        w_free_way   = '0;
        w_lru_way    = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
                w_up_hit     = 1'b1;
                w_up_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_up_idx][w]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_W'(w);
            end
            if (r_age[w_up_idx][w] == AGE_LRU) begin
                w_lru_way = WAY_W'(w);
            end
        end
        if (w_up_hit) begin
            w_way = w_up_hit_way;
        end else if (w_free_found) begin
            w_way = w_free_way;
        end else begin
            w_way = w_lru_way;
        end
    end

    // Post-update entry contents and LRU ages for the touched set
    always_comb begin
        w_old_ctr     = r_ctr[w_up_idx][w_way];
        w_old_target  = r_target[w_up_idx][w_way];
        w_touched_age = r_age[w_up_idx][w_way];
        w_new_ctr     = updateTaken ? CTR_WT : CTR_WNT;
        w_new_target  = updateTarget;
        if (w_up_hit) begin
            if (updateTaken) begin
                w_new_ctr = (w_old_ctr == CTR_MAX) ? CTR_MAX : w_old_ctr + CTR_W'(1);
            end else begin
                w_new_ctr    = (w_old_ctr == '0) ? '0 : w_old_ctr - CTR_W'(1);
                w_new_target = w_old_target;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_new_age[w] = r_age[w_up_idx][w];
            if (WAY_W'(w) == w_way) begin
                w_new_age[w] = '0;
            end else if (r_age[w_up_idx][w] < w_touched_age) begin
                w_new_age[w] = r_age[w_up_idx][w] + WAY_W'(1);
            end
        end
    end

    assign w_bypass = update && !flush && (updatePC[ADDR_W-1:2] == PC[ADDR_W-1:2]);

    // Prediction outputs, with the in-flight update taking priority on a PC match
    always_comb begin
        valid          = 1'b0;
        target         = '0;
        predictedTaken = 1'b0;
        evict          = 1'b0;
        if (!rst) begin
            evict = update && !flush && !w_up_hit && !w_free_found;
            if (w_bypass) begin
                valid          = 1'b1;
                target         = w_new_target;
                predictedTaken = w_new_ctr[CTR_W-1];
            end else if (w_lk_hit) begin
                valid          = 1'b1;
                target         = w_lk_target;
                predictedTaken = w_lk_ctr[CTR_W-1];
            end
        end
    end

    // Entry and age storage; flush keeps targets/tags but clears everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w]  <= 1'b0;
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_ctr[s][w]    <= '0;
                    r_age[s][w]    <= WAY_W'(w);
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_ctr[s][w]   <= '0;
                    r_age[s][w]   <= WAY_W'(w);
                end
            end
        end else if (update) begin
            r_valid[w_up_idx][w_way]  <= 1'b1;
            r_tag[w_up_idx][w_way]    <= w_up_tag;
            r_target[w_up_idx][w_way] <= w_new_target;
            r_ctr[w_up_idx][w_way]    <= w_new_ctr;
            for (int w = 0; w < NUM_WAYS; w++) begin
                r_age[w_up_idx][w] <= w_new_age[w];
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: a 2-way and a 4-way instance share stimulus and
// are checked against a recency-ordered list model of each set.
module tb_btb_assoc;

    localparam int NSETS = 8;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int WT    = 1 << (CW - 1);

    typedef struct {
        logic [31:0] tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    typedef struct packed {
        logic [1:0]       v;
        logic [1:0][31:0] tgt;
        logic [1:0]       pt;
        logic [1:0]       ev;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        upd_i;
    logic [31:0] upc_i;
    logic [31:0] utgt_i;
    logic        utk_i;
    logic        fl_i;

    logic [1:0]  v_o;
    logic [31:0] tgt_o [2];
    logic [1:0]  pt_o;
    logic [1:0]  ev_o;

    ent_t mdl [2*NSETS][$];
    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    btb_assoc #(.ADDR_W(32), .NUM_SETS(NSETS), .NUM_WAYS(2), .CTR_W(CW)) u_dut2 (
        .clk(clk), .rst(rst), .PC(pc_i), .update(upd_i), .updatePC(upc_i),
        .updateTarget(utgt_i), .updateTaken(utk_i), .flush(fl_i),
        .valid(v_o[0]), .target(tgt_o[0]), .predictedTaken(pt_o[0]), .evict(ev_o[0])
    );

    btb_assoc #(.ADDR_W(32), .NUM_SETS(NSETS), .NUM_WAYS(4), .CTR_W(CW)) u_dut4 (
        .clk(clk), .rst(rst), .PC(pc_i), .update(upd_i), .updatePC(upc_i),
        .updateTarget(utgt_i), .updateTaken(utk_i), .flush(fl_i),
        .valid(v_o[1]), .target(tgt_o[1]), .predictedTaken(pt_o[1]), .evict(ev_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ways_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % NSETS);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> 5;
    endfunction

    function automatic int find(input int k, input logic [31:0] tag);
        for (int i = 0; i < mdl[k].size(); i++) begin
            if (mdl[k][i].tag == tag) return i;
        end
        return -1;
    endfunction

    // Entry as it will look after training with this update
    function automatic ent_t post(input int k, input int i, input logic [31:0] upc,
                                  input logic [31:0] utgt, input logic tk);
        ent_t e;
        if (i >= 0) begin
            e = mdl[k][i];
            if (tk) begin
                e.ctr = (e.ctr == CMAX) ? CMAX : e.ctr + 1;
                e.tgt = utgt;
            end else begin
                e.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
            end
        end else begin
            e.tag = tag_of(upc);
            e.tgt = utgt;
            e.ctr = tk ? WT : WT - 1;
        end
        return e;
    endfunction

    function automatic void predict(input int d, input logic [31:0] pc, input logic upd,
                                    input logic [31:0] upc, input logic [31:0] utgt,
                                    input logic tk, input logic fl, inout exp_t x);
        int   ku;
        int   kl;
        int   iu;
        int   il;
        ent_t e;
        ku = d * NSETS + set_of(upc);
        kl = d * NSETS + set_of(pc);
        iu = find(ku, tag_of(upc));
        il = find(kl, tag_of(pc));
        x.v[d] = 1'b0; x.tgt[d] = '0; x.pt[d] = 1'b0;
        if (upd && !fl && (upc[31:2] == pc[31:2])) begin
            e = post(ku, iu, upc, utgt, tk);
            x.v[d] = 1'b1; x.tgt[d] = e.tgt; x.pt[d] = (e.ctr >= WT);
        end else if (il >= 0) begin
            x.v[d] = 1'b1; x.tgt[d] = mdl[kl][il].tgt; x.pt[d] = (mdl[kl][il].ctr >= WT);
        end
        x.ev[d] = upd && !fl && (iu < 0) && (mdl[ku].size() == ways_of(d));
    endfunction

    function automatic void apply(input int d, input logic upd, input logic [31:0] upc,
                                  input logic [31:0] utgt, input logic tk, input logic fl);
        int   ku;
        int   iu;
        ent_t e;
        if (fl) begin
            for (int s = 0; s < NSETS; s++) mdl[d*NSETS+s].delete();
        end else if (upd) begin
            ku = d * NSETS + set_of(upc);
            iu = find(ku, tag_of(upc));
            e  = post(ku, iu, upc, utgt, tk);
            if (iu >= 0) mdl[ku].delete(iu);
            else if (mdl[ku].size() == ways_of(d)) void'(mdl[ku].pop_back());
            mdl[ku].push_front(e);
        end
    endfunction

    function automatic void chk(input string name, input int d, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, d, act, req, $time);
        end
    endfunction

    task automatic step(input logic [31:0] pc, input logic upd, input logic [31:0] upc,
                        input logic [31:0] utgt, input logic tk, input logic fl);
        exp_t x;
        x = '0;
        pc_i = pc; upd_i = upd; upc_i = upc; utgt_i = utgt; utk_i = tk; fl_i = fl;
        for (int d = 0; d < 2; d++) predict(d, pc, upd, upc, utgt, tk, fl, x);
        exp_q.push_back(x);
        for (int d = 0; d < 2; d++) apply(d, upd, upc, utgt, tk, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic train(input logic [31:0] upc, input logic [31:0] utgt, input logic tk);
        step(32'h0000_0000, 1'b1, upc, utgt, tk, 1'b0);
    endtask

    task automatic chk_zero(input string tagname);
        for (int d = 0; d < 2; d++) begin
            chk({tagname, "_valid"}, d, 32'(v_o[d]), 32'h0);
            chk({tagname, "_target"}, d, tgt_o[d], 32'h0);
            chk({tagname, "_pt"}, d, 32'(pt_o[d]), 32'h0);
            chk({tagname, "_evict"}, d, 32'(ev_o[d]), 32'h0);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h000A_0000 + ((32'($urandom) % 6) << 5) + ((32'($urandom) % 8) << 2)
               + (32'($urandom) % 4);
    endfunction

    // Monitor: every cycle with a queued expectation, compare mid-cycle
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                chk("valid", d, 32'(v_o[d]), 32'(x.v[d]));
                chk("target", d, tgt_o[d], x.tgt[d]);
                chk("predictedTaken", d, 32'(pt_o[d]), 32'(x.pt[d]));
                chk("evict", d, 32'(ev_o[d]), 32'(x.ev[d]));
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] upc;
        rst = 1'b1; pc_i = '0; upd_i = 1'b0; upc_i = '0; utgt_i = '0; utk_i = 1'b0; fl_i = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, allocation, counter training and saturation
        step(32'h000A_0000, 1'b0, 32'h000A_0000, 32'h0, 1'b0, 1'b0);
        train(32'h000A_0000, 32'h000B_0000, 1'b1);
        look(32'h000A_0000);
        repeat (2) train(32'h000A_0000, 32'h000C_0000, 1'b0);
        look(32'h000A_0000);
        repeat (3) train(32'h000A_0000, 32'h000B_0000, 1'b1);
        look(32'h000A_0000);

        // Same-cycle bypass into a set with a free way
        step(32'h000A_0020, 1'b1, 32'h000A_0020, 32'h000B_0020, 1'b1, 1'b0);

        // Eviction in every set
        for (int s = 0; s < NSETS; s++) begin
            pc = 32'h000A_0000 + 32'(4 * s);
            if (s != 0) begin
                train(pc, pc + 32'h0001_0000, 1'b1);
                train(pc + 32'h20, pc + 32'h0001_0020, 1'b0);
            end
            train(pc + 32'h40, pc + 32'h0001_0040, 1'b1);
            look(pc + 32'h40);
            look(pc);
            look(pc + 32'h20);
        end

        // Flush with a colliding update: no bypass, no evict, then everything misses
        step(32'h000A_0040, 1'b1, 32'h000A_0040, 32'h0000_1234, 1'b1, 1'b1);
        for (int s = 0; s < NSETS; s++) begin
            look(32'h000A_0000 + 32'(4 * s));
            look(32'h000A_0040 + 32'(4 * s));
        end

        // True-LRU: touch 0,1,2,3,0 then allocate; way holding 0x20 goes in the 4-way
        train(32'h000A_0000, 32'h0000_1000, 1'b1);
        train(32'h000A_0020, 32'h0000_1020, 1'b1);
        train(32'h000A_0040, 32'h0000_1040, 1'b0);
        train(32'h000A_0060, 32'h0000_1060, 1'b1);
        train(32'h000A_0000, 32'h0000_2000, 1'b1);
        train(32'h000A_0080, 32'h0000_1080, 1'b1);
        look(32'h000A_0020);
        look(32'h000A_0000);
        look(32'h000A_0040);
        look(32'h000A_0080);

        // Async reset mid-update cancels the update and zeroes outputs at once
        pc_i = 32'h000A_0000; upd_i = 1'b1; upc_i = 32'h000A_0000; utgt_i = 32'h0000_5555;
        utk_i = 1'b1; fl_i = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        for (int d = 0; d < 2; d++) apply(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        look(32'h000A_0000);
        look(32'h000A_0080);

        // Random traffic over a small PC pool to provoke hits, conflicts and bypasses
        for (int n = 0; n < 1500; n++) begin
            pc  = rand_pc();
            upc = (($urandom % 4) == 0) ? pc : rand_pc();
            step(pc, 1'($urandom % 2), upc, $urandom, 1'($urandom % 2),
                 ($urandom % 40) == 0);
        end

        upd_i = 1'b0; fl_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative Branch Target Buffer for the RISC-V fetch stage.
- Generalises the fixed 8-set, 2-way BTB to N sets and M ways, with these additions:
  - true-LRU replacement
  - per-entry CTR_W-bit saturating direction counters, trained by the actual branch outcome
  - a synchronous flush
  - an eviction indicator
- Lookup is combinational on PC. Training occurs at the clk edge from the execute-stage update port, with same-cycle write-to-read bypass.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- NUM_SETS, 8, number of sets; power of 2, >=2.
- NUM_WAYS, 2, ways per set; power of 2, >=2.
- CTR_W, 2, direction counter width; >=1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- PC, input, ADDR_W, fetch PC to look up.
- update, input, 1, train/allocate using the updatePC/updateTarget/updateTaken fields.
- updatePC, input, ADDR_W, PC of the resolved branch.
- updateTarget, input, ADDR_W, resolved branch target.
- updateTaken, input, 1, actual outcome of the resolved branch.
- flush, input, 1, invalidate all entries at the next edge.
- valid, output, 1, PC hits a valid entry.
- target, output, ADDR_W, stored target on hit; 0 on miss.
- predictedTaken, output, 1, valid AND counter MSB.
- evict, output, 1, the current update allocates over a valid entry (combinational).

Behaviour:
- Address split:
  - IDX_W = log2(NUM_SETS).
  - Index = PC[IDX_W+1:2].
  - Tag = PC[ADDR_W-1:IDX_W+2]; PC[1:0] is ignored.
  - The same split applies to updatePC.
- Per-entry state: valid, tag, target, counter. Per-set state: one age field of log2(NUM_WAYS) bits per way.
- Reset (async, while rst=1):
  - all valid bits = 0, counters = 0, targets = 0.
  - age of way w = w.
  - Outputs: valid=0, target=0, predictedTaken=0, evict=0.
  - Reset asserted mid-update cancels the update.
- Lookup (combinational, zero latency):
  - On a tag hit in any valid way of the indexed set, drive valid=1, that way's target, and predictedTaken = counter MSB.
  - On a miss, valid=0, target=0, predictedTaken=0.
  - At most one way may match; the update logic guarantees this.
- Update with hit (update=1, updatePC tag found):
  - If updateTaken=1: counter increments, saturating at 2^CTR_W-1, and target is replaced by updateTarget.
  - If updateTaken=0: counter decrements, saturating at 0, and target is unchanged.
- Update with miss (allocation):
  - Victim is the lowest-indexed invalid way; if all ways are valid, the victim is the way with age NUM_WAYS-1 (LRU).
  - evict=1 that cycle only if the victim was valid.
  - Written entry: valid=1, tag, target=updateTarget.
  - Counter = 2^(CTR_W-1) if updateTaken=1 (weakly taken); otherwise 2^(CTR_W-1)-1 (weakly not-taken).
- LRU (touched only by updates, never by lookups):
  - The touched way gets age 0.
  - Ways whose age was less than the touched way's old age increment by 1.
  - Other ways are unchanged.
- Bypass:
  - Applies when update=1, flush=0, and updatePC==PC (bits [ADDR_W-1:2]).
  - Outputs reflect the post-update entry in the same cycle: valid=1, target = new target value, predictedTaken = MSB of the new counter value.
- Flush:
  - At the edge with flush=1: all valid bits, counters and ages return to reset values.
  - A simultaneous update is dropped; no bypass and evict=0 while flush=1.
  - Lookups during the flush cycle still see the pre-flush contents.
- Simultaneous update to one set and lookup of a different set or tag: independent. The lookup sees the old contents except when the bypass condition holds.

Test Plan:
- Reset, then update=0 with updatePC=0x000A0000, then PC=0x000A0000 -> valid=0, target=0, predictedTaken=0.
- update=1, updatePC=0x000A0000, updateTarget=0x000B0000, updateTaken=1; next cycle PC=0x000A0000 -> valid=1, target=0x000B0000, predictedTaken=1 (counter 2'b10). Then two updates with updateTaken=0 -> counter 2'b00, predictedTaken=0. Then three taken updates -> counter saturates at 2'b11.
- PC=updatePC=0x000A0020, updateTarget=0x000B0020, update=1 in the same cycle -> valid=1 and target=0x000B0020 in that cycle (bypass), evict=0 (the set had a free way).
- Set 0 holds 0x000A0000 (touched first) and 0x000A0020. Update 0x000A0040 -> evict=1. Then PC=0x000A0040 -> hit, target=0x000B0040; PC=0x000A0000 -> valid=0; PC=0x000A0020 -> still valid.
- Repeat the eviction scenario for sets 1-7 (PCs +4*set). Additionally, with NUM_WAYS=4, touch ways in the order 0,1,2,3,0 and then allocate -> way 1 is evicted.
- Fill several sets, assert flush together with update=1 -> no bypass and evict=0 that cycle; next cycle every previously valid PC returns valid=0. Also assert rst mid-sequence -> outputs go to 0 immediately (async).
